// File: rtl/mips32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mips32                                                        |
// | Brief    : 5-stage in-order MIPS32-subset pipeline (IF/ID/EX/MEM/WB)     |
// |            with on-chip instruction and data memories.                   |
// | Options  : define MIPS32_FWD_EN to forward EX operands from EX/MEM and    |
// |            MEM/WB; otherwise software must space dependent instructions. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mips32 #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);

  localparam int          c_IAW       = $clog2(IMEM_DEPTH);
  localparam int          c_DAW       = $clog2(DMEM_DEPTH);
  localparam logic [5:0]  c_OP_ADD    = 6'b000000;
  localparam logic [5:0]  c_OP_SUB    = 6'b000001;
  localparam logic [5:0]  c_OP_AND    = 6'b000010;
  localparam logic [5:0]  c_OP_OR     = 6'b000011;
  localparam logic [5:0]  c_OP_SLT    = 6'b000100;
  localparam logic [5:0]  c_OP_MUL    = 6'b000101;
  localparam logic [5:0]  c_OP_LW     = 6'b001000;
  localparam logic [5:0]  c_OP_SW     = 6'b001001;
  localparam logic [5:0]  c_OP_ADDI   = 6'b001010;
  localparam logic [5:0]  c_OP_SUBI   = 6'b001011;
  localparam logic [5:0]  c_OP_SLTI   = 6'b001100;
  localparam logic [5:0]  c_OP_BNEQZ  = 6'b001101;
  localparam logic [5:0]  c_OP_BEQZ   = 6'b001110;
  localparam logic [5:0]  c_OP_HLT    = 6'b111111;
  // Bubbles carry an undefined opcode so every later stage treats them as NOP
  localparam logic [5:0]  c_OP_BUBBLE = 6'b111110;
  localparam logic [31:0] c_BUBBLE_IR = {c_OP_BUBBLE, 26'd0};

  // Architectural state (arrays deliberately unreset so preloads survive)
  logic [31:0] reg_bank [0:31];
  logic [31:0] mem_inst [0:IMEM_DEPTH-1];
  logic [31:0] mem_data [0:DMEM_DEPTH-1];
  logic [31:0] pc;
  logic        taken_branch;
  logic        halt_pend_q;

  // Pipeline registers; a write-enable of 0 plus bubble opcode means "no effect"
  logic [31:0] if_id_ir_q, if_id_npc_q;
  logic [5:0]  id_ex_op_q;
  logic [4:0]  id_ex_rs_q, id_ex_rt_q, id_ex_dst_q;
  logic        id_ex_we_q;
  logic [31:0] id_ex_a_q, id_ex_b_q, id_ex_imm_q, id_ex_npc_q;
  logic [5:0]  ex_mem_op_q;
  logic [4:0]  ex_mem_dst_q;
  logic        ex_mem_we_q;
  logic [31:0] ex_mem_alu_q, ex_mem_b_q;
  logic        mem_wb_we_q;
  logic [4:0]  mem_wb_dst_q;
  logic [31:0] mem_wb_data_q;

  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dst;
  logic [31:0] id_imm, id_a, id_b;
  logic        id_rtype, id_writes, id_hlt, wb_we, fetch_stall;
  logic [31:0] ex_a, ex_b, ex_alu, mem_rdata;
  logic        ex_taken;

  assign id_op       = if_id_ir_q[31:26];
  assign id_rs       = if_id_ir_q[25:21];
  assign id_rt       = if_id_ir_q[20:16];
  assign id_rd       = if_id_ir_q[15:11];
  assign id_imm      = {{16{if_id_ir_q[15]}}, if_id_ir_q[15:0]};
  assign id_rtype    = (id_op <= c_OP_MUL);
  assign id_writes   = id_rtype || (id_op inside {c_OP_LW, c_OP_ADDI, c_OP_SUBI, c_OP_SLTI});
  assign id_dst      = id_rtype ? id_rd : id_rt;
  // A branch resolving in EX outranks a HLT sitting behind it in ID
  assign id_hlt      = (id_op == c_OP_HLT) && !ex_taken;
  assign fetch_stall = id_hlt || halt_pend_q;
  // Write enables are only ever set for non-zero destinations
  assign wb_we       = mem_wb_we_q && !halted;
  assign mem_rdata   = mem_data[ex_mem_alu_q[c_DAW-1:0]];

  // ID register read; a same-cycle WB write is returned instead of the stale entry
  always_comb begin
    id_a = (id_rs == 5'd0) ? 32'd0 : reg_bank[id_rs];
    id_b = (id_rt == 5'd0) ? 32'd0 : reg_bank[id_rt];
    if (wb_we && (mem_wb_dst_q == id_rs)) id_a = mem_wb_data_q;
    if (wb_we && (mem_wb_dst_q == id_rt)) id_b = mem_wb_data_q;
  end

  // EX operand selection; a load in EX/MEM has no data yet so it is never a source
  always_comb begin
    ex_a = id_ex_a_q;
    ex_b = id_ex_b_q;
`ifdef MIPS32_FWD_EN
    if (ex_mem_we_q && (ex_mem_op_q != c_OP_LW) && (ex_mem_dst_q == id_ex_rs_q))
      ex_a = ex_mem_alu_q;
    else if (wb_we && (mem_wb_dst_q == id_ex_rs_q))
      ex_a = mem_wb_data_q;
    if (ex_mem_we_q && (ex_mem_op_q != c_OP_LW) && (ex_mem_dst_q == id_ex_rt_q))
      ex_b = ex_mem_alu_q;
    else if (wb_we && (mem_wb_dst_q == id_ex_rt_q))
      ex_b = mem_wb_data_q;
`endif
  end

  // ALU, address generation, branch target and branch decision
  always_comb begin
    ex_alu   = 32'd0;
    ex_taken = 1'b0;
    case (id_ex_op_q)
      c_OP_ADD:   ex_alu = ex_a + ex_b;
      c_OP_SUB:   ex_alu = ex_a - ex_b;
      c_OP_AND:   ex_alu = ex_a & ex_b;
      c_OP_OR:    ex_alu = ex_a | ex_b;
      c_OP_SLT:   ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
      c_OP_MUL:   ex_alu = ex_a * ex_b;
      c_OP_LW,
      c_OP_SW,
      c_OP_ADDI:  ex_alu = ex_a + id_ex_imm_q;
      c_OP_SUBI:  ex_alu = ex_a - id_ex_imm_q;
      c_OP_SLTI:  ex_alu = {31'd0, $signed(ex_a) < $signed(id_ex_imm_q)};
      c_OP_BNEQZ: begin
        ex_alu   = id_ex_npc_q + id_ex_imm_q;
        ex_taken = (ex_a != 32'd0);
      end
      c_OP_BEQZ: begin
        ex_alu   = id_ex_npc_q + id_ex_imm_q;
        ex_taken = (ex_a == 32'd0);
      end
      default:    ex_alu = 32'd0;
    endcase
  end

  // Pipeline advance: fetch, squash on taken branch, freeze on HLT
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= 32'd0;
      taken_branch  <= 1'b0;
      halted        <= 1'b0;
      halt_pend_q   <= 1'b0;
      if_id_ir_q    <= c_BUBBLE_IR;
      if_id_npc_q   <= 32'd0;
      id_ex_op_q    <= c_OP_BUBBLE;
      id_ex_rs_q    <= 5'd0;
      id_ex_rt_q    <= 5'd0;
      id_ex_dst_q   <= 5'd0;
      id_ex_we_q    <= 1'b0;
      id_ex_a_q     <= 32'd0;
      id_ex_b_q     <= 32'd0;
      id_ex_imm_q   <= 32'd0;
      id_ex_npc_q   <= 32'd0;
      ex_mem_op_q   <= c_OP_BUBBLE;
      ex_mem_dst_q  <= 5'd0;
      ex_mem_we_q   <= 1'b0;
      ex_mem_alu_q  <= 32'd0;
      ex_mem_b_q    <= 32'd0;
      mem_wb_we_q   <= 1'b0;
      mem_wb_dst_q  <= 5'd0;
      mem_wb_data_q <= 32'd0;
    end else begin
      taken_branch <= ex_taken;
      halt_pend_q  <= halt_pend_q || id_hlt;
      halted       <= halted || (ex_mem_op_q == c_OP_HLT);

      if (ex_taken) begin
        pc         <= ex_alu;
        if_id_ir_q <= c_BUBBLE_IR;
      end else if (fetch_stall) begin
        if_id_ir_q <= c_BUBBLE_IR;
      end else begin
        if_id_ir_q  <= mem_inst[pc[c_IAW-1:0]];
        if_id_npc_q <= pc + 32'd1;
        pc          <= pc + 32'd1;
      end

      id_ex_op_q  <= ex_taken ? c_OP_BUBBLE : id_op;
      id_ex_we_q  <= !ex_taken && id_writes && (id_dst != 5'd0);
      id_ex_rs_q  <= id_rs;
      id_ex_rt_q  <= id_rt;
      id_ex_dst_q <= id_dst;
      id_ex_a_q   <= id_a;
      id_ex_b_q   <= id_b;
      id_ex_imm_q <= id_imm;
      id_ex_npc_q <= if_id_npc_q;

      ex_mem_op_q  <= id_ex_op_q;
      ex_mem_we_q  <= id_ex_we_q;
      ex_mem_dst_q <= id_ex_dst_q;
      ex_mem_alu_q <= ex_alu;
      ex_mem_b_q   <= ex_b;

      mem_wb_we_q   <= ex_mem_we_q;
      mem_wb_dst_q  <= ex_mem_dst_q;
      mem_wb_data_q <= (ex_mem_op_q == c_OP_LW) ? mem_rdata : ex_mem_alu_q;
    end
  end

  // Register file write port (WB)
  always_ff @(posedge clk1) begin
    if (wb_we) reg_bank[mem_wb_dst_q] <= mem_wb_data_q;
  end

  // Data memory store port (MEM)
  always_ff @(posedge clk1) begin
    if ((ex_mem_op_q == c_OP_SW) && !halted) mem_data[ex_mem_alu_q[c_DAW-1:0]] <= ex_mem_b_q;
  end

  // Address bits beyond the memory depth and, without forwarding, the source tags
  logic w_unused;
  assign w_unused = &{1'b0, pc[31:c_IAW], ex_mem_alu_q[31:c_DAW], id_ex_rs_q, id_ex_rt_q, 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_mips32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mips32                                                     |
// | Brief    : Directed programs for mips32; architectural results queued    |
// |            as expectations and compared once the core halts.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mips32;

  localparam logic [5:0]  OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010;
  localparam logic [5:0]  OP_OR = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101;
  localparam logic [5:0]  OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010;
  localparam logic [5:0]  OP_SUBI = 6'b001011, OP_SLTI = 6'b001100;
  localparam logic [5:0]  OP_BNEQZ = 6'b001101, OP_BEQZ = 6'b001110;
  localparam logic [31:0] NOP = 32'hf000_0000;
  localparam logic [31:0] HLT = 32'hfc00_0000;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  always #5 clk1 = ~clk1;

  mips32 #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .halted (halted)
  );

  typedef struct {
    bit          is_mem;
    int          addr;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_taken  = 0;
  int          cyc      = 0;
  logic [31:0] pc_at_halt;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_reg(input string tag, input int idx, input logic [31:0] val);
    exp_t e;
    e.is_mem = 1'b0; e.addr = idx; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_mem(input string tag, input int addr, input logic [31:0] val);
    exp_t e;
    e.is_mem = 1'b1; e.addr = addr; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_mem) check(e.tag, dut.mem_data[e.addr], e.val);
      else          check(e.tag, dut.reg_bank[e.addr], e.val);
    end
  endtask

  // Registers get R[k]=k; instruction memory is NOP-filled then loaded with prog
  task automatic setup();
    for (int k = 0; k < 32; k++) dut.reg_bank[k] = 32'(k);
    for (int i = 0; i < 1024; i++) dut.mem_inst[i] = NOP;
    for (int i = 0; i < prog.size(); i++) dut.mem_inst[i] = prog[i];
  endtask

  task automatic enter_reset();
    @(negedge clk1);
    #2 rst_n = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, input int max);
    cyc = 0;
    n_taken = 0;
    while (halted !== 1'b1 && cyc < max) begin
      @(negedge clk1);
      cyc++;
      if (dut.taken_branch === 1'b1) n_taken++;
    end
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    pc_at_halt = dut.pc;
  endtask

  task automatic push_s1();
    expect_reg("s1_r0", 0, 32'd0);
    expect_reg("s1_r1", 1, 32'd10);
    expect_reg("s1_r2", 2, 32'd20);
    expect_reg("s1_r3", 3, 32'd25);
    expect_reg("s1_r4", 4, 32'd30);
`ifdef MIPS32_FWD_EN
    expect_reg("s1_r5", 5, 32'd55);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- Program-and-reset scenario ----------------
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    #1 setup();
    check("rst_pc", dut.pc, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_taken", {31'd0, dut.taken_branch}, 32'd0);
    release_reset();
    push_s1();
    run_to_halt("s1", 40);
    check("s1_latency_le15", {31'd0, (cyc <= 15)}, 32'd1);
    drain();

    // Reset after halt drops halted and pc immediately
    enter_reset();
    #1 check("s1_rst_pc", dut.pc, 32'd0);
    check("s1_rst_halted", {31'd0, halted}, 32'd0);
    setup();
    release_reset();
    repeat (6) @(negedge clk1);
    #2 rst_n = 1'b0;
    #1 check("s1_midrst_pc", dut.pc, 32'd0);
    check("s1_midrst_halted", {31'd0, halted}, 32'd0);
    release_reset();
    push_s1();
    run_to_halt("s1_rerun", 40);
    drain();

    // ---------------- Forwarding scenario ----------------
    enter_reset();
`ifdef MIPS32_FWD_EN
    prog = '{enc_i(OP_ADDI, 0, 1, 5), enc_r(OP_ADD, 1, 1, 2), enc_r(OP_SUB, 2, 1, 3), HLT};
`else
    prog = '{enc_i(OP_ADDI, 0, 1, 5), NOP, NOP, enc_r(OP_ADD, 1, 1, 2), NOP, NOP,
             enc_r(OP_SUB, 2, 1, 3), HLT};
`endif
    setup();
    release_reset();
    expect_reg("fwd_r2", 2, 32'd10);
    expect_reg("fwd_r3", 3, 32'd5);
    run_to_halt("fwd", 60);
    drain();

    // ---------------- Load/store scenario ----------------
    enter_reset();
    prog = '{enc_i(OP_ADDI, 0, 1, 120), NOP, NOP, enc_i(OP_LW, 1, 2, 0), NOP, NOP,
             enc_i(OP_ADDI, 2, 3, 45), NOP, NOP, enc_i(OP_SW, 1, 3, 1), HLT};
    setup();
    dut.mem_data[120] = 32'd85;
    dut.mem_data[121] = 32'd0;
    release_reset();
    expect_reg("ls_r2", 2, 32'd85);
    expect_reg("ls_r3", 3, 32'd130);
    expect_mem("ls_mem121", 121, 32'd130);
    run_to_halt("ls", 60);
    drain();

    // ---------------- Branch-loop scenario ----------------
    enter_reset();
`ifdef MIPS32_FWD_EN
    prog = '{enc_i(OP_ADDI, 0, 1, 3), enc_i(OP_ADDI, 2, 2, 1), enc_i(OP_SUBI, 1, 1, 1),
             enc_i(OP_BNEQZ, 1, 0, -3), enc_i(OP_ADDI, 0, 4, 7), HLT};
`else
    prog = '{enc_i(OP_ADDI, 0, 1, 3), NOP, NOP, enc_i(OP_ADDI, 2, 2, 1), enc_i(OP_SUBI, 1, 1, 1),
             NOP, NOP, enc_i(OP_BNEQZ, 1, 0, -5), enc_i(OP_ADDI, 0, 4, 7), HLT};
`endif
    setup();
    dut.reg_bank[2] = 32'd100;
    dut.reg_bank[4] = 32'd0;
    release_reset();
    expect_reg("br_r1", 1, 32'd0);
    expect_reg("br_r2", 2, 32'd103);
    expect_reg("br_r4", 4, 32'd7);
    run_to_halt("br", 120);
    check("br_taken_pulses", 32'(n_taken), 32'd2);
    drain();

    // ---------------- ALU coverage with a taken BEQZ skipping one slot ----------------
    enter_reset();
    prog = '{enc_i(OP_ADDI, 0, 1, -6), enc_i(OP_ADDI, 0, 2, 7), NOP, NOP,
             enc_r(OP_MUL, 1, 2, 3), enc_r(OP_SLT, 1, 2, 4), enc_r(OP_AND, 1, 2, 5),
             enc_r(OP_OR, 1, 2, 6), enc_i(OP_SLTI, 1, 7, -5), enc_r(OP_SUB, 2, 1, 8),
             enc_i(OP_BEQZ, 0, 0, 1), enc_i(OP_ADDI, 0, 9, 1), enc_i(OP_ADDI, 0, 10, 2), HLT};
    setup();
    release_reset();
    expect_reg("alu_mul", 3, 32'hffff_ffd6);
    expect_reg("alu_slt", 4, 32'd1);
    expect_reg("alu_and", 5, 32'd2);
    expect_reg("alu_or", 6, 32'hffff_ffff);
    expect_reg("alu_slti", 7, 32'd1);
    expect_reg("alu_sub", 8, 32'd13);
    expect_reg("beqz_skipped", 9, 32'd9);
    expect_reg("beqz_target", 10, 32'd2);
    run_to_halt("alu", 80);
    check("beqz_taken_pulses", 32'(n_taken), 32'd1);
    drain();

    // ---------------- Halt / R0 scenario ----------------
    enter_reset();
    prog = '{enc_i(OP_ADDI, 0, 0, 5), HLT, enc_i(OP_ADDI, 0, 6, 9)};
    setup();
    release_reset();
    expect_reg("hlt_r0", 0, 32'd0);
    expect_reg("hlt_r6", 6, 32'd6);
    run_to_halt("hlt", 40);
    check("hlt_pc_at_halt", pc_at_halt, 32'd2);
    repeat (5) @(negedge clk1);
    check("hlt_pc_frozen", dut.pc, 32'd2);
    check("hlt_still_halted", {31'd0, halted}, 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
